// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one i2cmaster among NUM_REQ clients.
// Optional per-transaction abort: define I2C_ARB_TIMEOUT_EN (uses TIMEOUT_CYC).
module i2c_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_rw,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [7:0]           rd_data,
  output logic                 err,
  output logic                 busy,
  output logic [6:0]           m_addr,
  output logic [7:0]           m_data_in,
  output logic                 m_rw,
  output logic                 m_enable,
  input  logic                 m_ready,
  input  logic [7:0]           m_data_out
);

  localparam int IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {ARB, LAUNCH, WAIT, DONE} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   cur_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] done_q;
  logic [7:0]         rd_data_q;
  logic [6:0]         m_addr_q;
  logic [7:0]         m_data_q;
  logic               m_rw_q;
  logic               m_enable_q;

  logic               win_valid;
  logic [IDX_W-1:0]   win_idx;
  logic               timeout_hit;
  logic               timed_out;

  function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDX_W'(sum);
  endfunction

  // Scan downward so the smallest offset from the pointer is the last (winning) assignment.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[rot_idx(ptr_q, k)]) begin
        win_valid = 1'b1;
        win_idx   = rot_idx(ptr_q, k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB;
      ptr_q      <= '0;
      cur_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      rd_data_q  <= '0;
      m_addr_q   <= '0;
      m_data_q   <= '0;
      m_rw_q     <= 1'b0;
      m_enable_q <= 1'b0;
    end else begin
      done_q <= '0;
      case (state_q)
        ARB: begin
          if (win_valid) begin
            gnt_q      <= NUM_REQ'(1) << win_idx;
            cur_q      <= win_idx;
            m_addr_q   <= req_addr[int'(win_idx)*7 +: 7];
            m_data_q   <= req_data[int'(win_idx)*8 +: 8];
            m_rw_q     <= req_rw[win_idx];
            m_enable_q <= 1'b1;
            state_q    <= LAUNCH;
          end
        end
        LAUNCH: begin
          // Enable drops as soon as the master leaves IDLE so it issues STOP after the byte.
          if (timeout_hit) begin
            m_enable_q <= 1'b0;
            state_q    <= DONE;
          end else if (!m_ready) begin
            m_enable_q <= 1'b0;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (timeout_hit || m_ready) state_q <= DONE;
        end
        DONE: begin
          done_q <= gnt_q;
          gnt_q  <= '0;
          if (m_rw_q && !timed_out) rd_data_q <= m_data_out;
          ptr_q   <= (int'(cur_q) == NUM_REQ - 1) ? '0 : cur_q + IDX_W'(1);
          state_q <= ARB;
        end
        default: state_q <= ARB;
      endcase
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

  logic [CNT_W-1:0] to_cnt_q;
  logic             to_flag_q;
  logic             err_q;

  // Counter lands on TIMEOUT_CYC-1 on the same edge that moves the FSM to DONE.
  assign timeout_hit = ((state_q == LAUNCH) || (state_q == WAIT)) &&
                       (to_cnt_q == CNT_W'(TIMEOUT_CYC - 2));
  assign timed_out   = to_flag_q;
  assign err         = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= (state_q == DONE) && to_flag_q;
      if (state_q == ARB) begin
        to_cnt_q  <= '0;
        to_flag_q <= 1'b0;
      end else if ((state_q == LAUNCH) || (state_q == WAIT)) begin
        to_cnt_q <= to_cnt_q + CNT_W'(1);
        if (timeout_hit) to_flag_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timed_out   = 1'b0;
  assign err         = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rd_data   = rd_data_q;
  assign busy      = (state_q != ARB);
  assign m_addr    = m_addr_q;
  assign m_data_in = m_data_q;
  assign m_rw      = m_rw_q;
  assign m_enable  = m_enable_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter with a behavioural i2cmaster handshake stub.
module tb_i2c_req_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [7*N-1:0] req_addr = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_rw = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [7:0]     rd_data;
  logic           err;
  logic           busy;
  logic [6:0]     m_addr;
  logic [7:0]     m_data_in;
  logic           m_rw;
  logic           m_enable;
  logic           m_ready;
  logic [7:0]     m_data_out;

  int n_vec = 0;
  int n_err = 0;

  // master stub controls and observations
  int         stub_len = 6;
  bit         stub_stall = 1'b0;
  logic [7:0] stub_rd = 8'h00;
  logic       st_ready;
  int         st_cnt;
  logic [6:0] st_addr;
  logic [7:0] st_data;
  logic       st_rw;
  bit         st_en_late = 1'b0;

  always #5 clk = ~clk;

  i2c_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_rw     (req_rw),
    .gnt        (gnt),
    .done       (done),
    .rd_data    (rd_data),
    .err        (err),
    .busy       (busy),
    .m_addr     (m_addr),
    .m_data_in  (m_data_in),
    .m_rw       (m_rw),
    .m_enable   (m_enable),
    .m_ready    (m_ready),
    .m_data_out (m_data_out)
  );

  assign m_ready    = st_ready;
  assign m_data_out = stub_rd;

  // Ready drops the edge after enable is seen; completion with enable still high would mean a restart.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_ready <= 1'b1;
      st_cnt   <= 0;
    end else if (st_ready) begin
      if (m_enable) begin
        st_ready <= 1'b0;
        st_cnt   <= stub_len;
        st_addr  <= m_addr;
        st_data  <= m_data_in;
        st_rw    <= m_rw;
      end
    end else if (!stub_stall) begin
      if (st_cnt == 0) begin
        st_ready <= 1'b1;
        if (m_enable) st_en_late <= 1'b1;
      end else begin
        st_cnt <= st_cnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_client(input int cl, input logic [6:0] a, input logic [7:0] d, input logic rw);
    req_addr[7*cl +: 7] = a;
    req_data[8*cl +: 8] = d;
    req_rw[cl]          = rw;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_txn(input int cl, input string tag, input logic [6:0] ea, input logic [7:0] ed,
                        input logic erw, input logic [7:0] erd, input bit drop);
    int lat;
    int cyc;
    bit seen;
    bit hold_ok;
    logic [N-1:0] eg;
    eg  = N'(1) << cl;
    lat = 0;
    while (gnt == '0 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".gnt"}, gnt, eg);
    chk({tag, ".en"}, m_enable, 1);
    hold_ok = 1'b1;
    seen    = 1'b0;
    cyc     = 0;
    while (!seen && cyc < 300) begin
      if (gnt != eg || m_addr != ea || m_data_in != ed || m_rw != erw) hold_ok = 1'b0;
      @(negedge clk);
      cyc++;
      if (done != '0) seen = 1'b1;
    end
    chk({tag, ".done_seen"}, seen, 1);
    chk({tag, ".done"}, done, eg);
    chk({tag, ".err"}, err, 0);
    chk({tag, ".gnt_off"}, gnt, 0);
    chk({tag, ".rd_data"}, rd_data, erd);
    chk({tag, ".hold"}, hold_ok, 1);
    chk({tag, ".st_addr"}, st_addr, ea);
    chk({tag, ".st_data"}, st_data, ed);
    chk({tag, ".st_rw"}, st_rw, erw);
    chk({tag, ".en_late"}, st_en_late, 0);
    if (drop) req[cl] = 1'b0;
    @(negedge clk);
    chk({tag, ".single"}, done, 0);
  endtask

  initial begin
    int cyc;
    int ndone;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst.gnt", gnt, 0);
    chk("rst.done", done, 0);
    chk("rst.rd_data", rd_data, 0);
    chk("rst.err", err, 0);
    chk("rst.busy", busy, 0);
    chk("rst.m_enable", m_enable, 0);
    chk("rst.m_addr", m_addr, 0);
    chk("rst.m_data_in", m_data_in, 0);
    chk("rst.m_rw", m_rw, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle.busy", busy, 0);

    // 1: write on client 0; inputs changed after grant must be ignored
    stub_rd = 8'h77;
    set_client(0, 7'h50, 8'h3C, 1'b0);
    req[0] = 1'b1;
    @(negedge clk);
    chk("t1.gnt_t1", gnt, 4'b0001);
    chk("t1.busy", busy, 1);
    set_client(0, 7'h11, 8'hEE, 1'b1);
    do_txn(0, "t1", 7'h50, 8'h3C, 1'b0, 8'h00, 1'b1);

    // 2: read on client 1
    stub_rd = 8'hA5;
    set_client(1, 7'h48, 8'h00, 1'b1);
    req[1] = 1'b1;
    do_txn(1, "t2", 7'h48, 8'h00, 1'b1, 8'hA5, 1'b1);

    // 3: contention from reset
    do_reset();
    set_client(0, 7'h20, 8'h01, 1'b0);
    set_client(2, 7'h22, 8'h02, 1'b0);
    req = 4'b0101;
    do_txn(0, "t3a", 7'h20, 8'h01, 1'b0, 8'h00, 1'b1);
    do_txn(2, "t3b", 7'h22, 8'h02, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    chk("t3.idle_gnt", gnt, 0);
    chk("t3.idle_busy", busy, 0);

    // 4: fairness with all clients requesting continuously
    do_reset();
    for (int i = 0; i < N; i++) set_client(i, 7'(8'h30 + i), 8'(8'h40 + i), 1'b0);
    req = 4'b1111;
    for (int r = 0; r < 8; r++)
      do_txn(r % N, $sformatf("t4.%0d", r), 7'(8'h30 + (r % N)), 8'(8'h40 + (r % N)), 1'b0, 8'h00, 1'b0);
    do_reset();

    // 5: master never completes
    stub_stall = 1'b1;
    stub_rd    = 8'hC3;
    set_client(2, 7'h2A, 8'h55, 1'b1);
    req = 4'b0100;
    cyc = 0;
    while (gnt == '0 && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    chk("t5.gnt", gnt, 4'b0100);
`ifdef I2C_ARB_TIMEOUT_EN
    cyc = 0;
    while (done == '0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("t5.to_cycles", cyc, 64);
    chk("t5.done", done, 4'b0100);
    chk("t5.err", err, 1);
    chk("t5.m_enable", m_enable, 0);
    chk("t5.rd_data", rd_data, 0);
`else
    ndone = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done != '0) ndone++;
    end
    chk("t5.no_done", ndone, 0);
    chk("t5.busy", busy, 1);
    chk("t5.err", err, 0);
`endif
    stub_stall = 1'b0;
    do_reset();

    // 6: asynchronous reset in the middle of a read
    stub_len = 20;
    stub_rd  = 8'h5A;
    set_client(1, 7'h48, 8'h00, 1'b1);
    req = 4'b0010;
    cyc = 0;
    while (!(busy && !m_enable && gnt != '0) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("t6.in_wait", busy && !m_enable, 1);
    rst_n = 1'b0;
    #1;
    chk("t6.gnt", gnt, 0);
    chk("t6.m_enable", m_enable, 0);
    chk("t6.busy", busy, 0);
    chk("t6.done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_client(3, 7'h3F, 8'h99, 1'b0);
    req = 4'b1000;
    do_txn(3, "t6", 7'h3F, 8'h99, 1'b0, 8'h00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule
